// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI responder.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;
    localparam int unsigned SPI_BIT_W  = $clog2(SPI_WORD_W);

    typedef enum logic {IDLE, SHIFT} spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one pin, with a history flop for rise/fall detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o  = sync_q[SYNC_STAGES-1];
    assign rise_c_o =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_c_o = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled entirely in the clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BYTE_CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic                  tx_load,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic [BYTE_CNT_W-1:0] byte_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort
);

    localparam logic [SPI_BIT_W-1:0] LAST_BIT = SPI_BIT_W'(SPI_WORD_W - 1);

    logic sclk_lvl, sclk_rise_c, sclk_fall_c;
    logic cs_lvl, cs_rise_c, cs_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic sync_unused_c;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk), .rst_i(rst), .d_i(sclk),
        .level_o(sclk_lvl), .rise_c_o(sclk_rise_c), .fall_c_o(sclk_fall_c)
    );

    // cs idles high, so its chain resets high to avoid a spurious edge on release
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk), .rst_i(rst), .d_i(cs),
        .level_o(cs_lvl), .rise_c_o(cs_rise_c), .fall_c_o(cs_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_i(rst), .d_i(mosi),
        .level_o(mosi_lvl), .rise_c_o(mosi_rise_c), .fall_c_o(mosi_fall_c)
    );

    assign sync_unused_c = ^{sclk_lvl, cs_lvl, mosi_rise_c, mosi_fall_c};

    spi_slv_state_t        state_q;
    logic [SPI_WORD_W-1:0] tx_shift_q;
    logic [SPI_WORD_W-1:0] rx_shift_q;
    logic [SPI_BIT_W-1:0]  bit_cnt_q;
    logic [BYTE_CNT_W-1:0] byte_idx_q;
    logic [SPI_WORD_W-1:0] rx_data_q;
    logic                  rx_pend_q;
    logic                  got_byte_q;
    logic                  seen_rise_q;
    logic                  miso_q, busy_q, tx_load_q, rx_valid_q;
    logic                  frame_done_q, frame_abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            byte_idx_q    <= '0;
            rx_data_q     <= '0;
            rx_pend_q     <= 1'b0;
            got_byte_q    <= 1'b0;
            seen_rise_q   <= 1'b0;
            miso_q        <= 1'b0;
            busy_q        <= 1'b0;
            tx_load_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            tx_load_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            rx_pend_q     <= 1'b0;

            // a byte completed on the previous cycle is published even if cs just rose
            if (rx_pend_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (cs_fall_c) begin
                        state_q     <= SHIFT;
                        tx_shift_q  <= tx_data;
                        tx_load_q   <= 1'b1;
                        miso_q      <= tx_data[SPI_WORD_W-1];
                        bit_cnt_q   <= '0;
                        byte_idx_q  <= '0;
                        busy_q      <= 1'b1;
                        got_byte_q  <= 1'b0;
                        seen_rise_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise_c) begin
                        state_q       <= IDLE;
                        miso_q        <= 1'b0;
                        busy_q        <= 1'b0;
                        bit_cnt_q     <= '0;
                        frame_done_q  <= (bit_cnt_q == '0) && got_byte_q;
                        frame_abort_q <= (bit_cnt_q != '0);
                    end else if (sclk_rise_c) begin
                        rx_shift_q  <= {rx_shift_q[SPI_WORD_W-2:0], mosi_lvl};
                        bit_cnt_q   <= bit_cnt_q + SPI_BIT_W'(1);
                        seen_rise_q <= 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_pend_q  <= 1'b1;
                            got_byte_q <= 1'b1;
                        end
                    end else if (sclk_fall_c && seen_rise_q) begin
                        if (bit_cnt_q != '0) begin
                            tx_shift_q <= {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
                            miso_q     <= tx_shift_q[SPI_WORD_W-2];
                        end else begin
                            tx_shift_q <= tx_data;
                            tx_load_q  <= 1'b1;
                            byte_idx_q <= byte_idx_q + BYTE_CNT_W'(1);
                            miso_q     <= tx_data[SPI_WORD_W-1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = miso_q;
    assign busy        = busy_q;
    assign tx_load     = tx_load_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign byte_idx    = byte_idx_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged mode-0 master plus an event-level frame model.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] byte_idx;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;

    spi_slave #(.SYNC_STAGES(2), .BYTE_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
        .byte_idx(byte_idx), .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rxq[$];
    logic [7:0] s_txq[$];
    int n_load = 0;
    int n_done = 0;
    int n_abort = 0;

    logic [7:0] m_tx[16];
    logic [7:0] m_rx[16];
    logic [1:0] m_idx[16];

    // passive monitor; also the slave-side tx_data producer
    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (frame_done) n_done++;
        if (frame_abort) n_abort++;
        if (tx_load) begin
            n_load++;
            if (s_txq.size() > 0) void'(s_txq.pop_front());
        end
        tx_data = (s_txq.size() > 0) ? s_txq[0] : 8'h00;
    end

    // mode-0 master: last sclk fall coincides with the cs rise
    task automatic master_frame(input int nbits);
        @(negedge clk);
        cs = 1'b0;
        mosi = m_tx[0][7];
        for (int b = 0; b < nbits; b++) begin
            repeat (HALF) @(negedge clk);
            m_rx[b/8][7 - (b%8)] = miso;
            if (b % 8 == 4) m_idx[b/8] = byte_idx;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (b == nbits - 1) cs = 1'b1;
            else mosi = m_tx[(b+1)/8][7 - ((b+1)%8)];
        end
        if (nbits == 0) begin
            repeat (HALF) @(negedge clk);
            cs = 1'b1;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        int l0, r0, d0, a0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sclk = ~sclk;
            cs = (i % 2 == 0);
            @(negedge clk);
            n_vec++;
            if ({miso, busy, rx_valid, tx_load, byte_idx, rx_data} !== 14'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got miso=%b busy=%b rv=%b tl=%b idx=%0d rx=%h, need all 0",
                         miso, busy, rx_valid, tx_load, byte_idx, rx_data);
            end
        end
        cs = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        l0 = n_load; r0 = rxq.size(); d0 = n_done; a0 = n_abort;
        for (int i = 0; i < 10; i++) begin
            sclk = ~sclk;
            repeat (HALF) @(negedge clk);
        end
        n_vec++;
        if (n_load != l0 || rxq.size() != r0 || n_done != d0 || n_abort != a0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_sclk_ignored: loads+%0d rx+%0d done+%0d abort+%0d busy=%b, need all 0",
                     n_load - l0, rxq.size() - r0, n_done - d0, n_abort - a0, busy);
        end
    endtask

    task automatic test_single;
        int l0, r0, d0, a0;
        l0 = n_load; r0 = rxq.size(); d0 = n_done; a0 = n_abort;
        s_txq.push_back(8'hA5);
        m_tx[0] = 8'h3C;
        master_frame(8);
        n_vec++;
        if (m_rx[0] !== 8'hA5) begin
            n_err++; $display("FAIL single_miso: got %h need a5", m_rx[0]);
        end
        n_vec++;
        if (rxq.size() - r0 != 1 || rx_data !== 8'h3C) begin
            n_err++; $display("FAIL single_rx: got %0d bytes rx_data=%h need 1 byte 3c", rxq.size() - r0, rx_data);
        end
        n_vec++;
        if (n_done - d0 != 1 || n_abort != a0 || n_load - l0 != 1) begin
            n_err++;
            $display("FAIL single_pulses: done+%0d abort+%0d loads+%0d need 1/0/1", n_done - d0, n_abort - a0, n_load - l0);
        end
        n_vec++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            n_err++; $display("FAIL single_idle: busy=%b miso=%b need 0/0", busy, miso);
        end
    endtask

    task automatic test_four;
        int l0, r0, d0;
        l0 = n_load; r0 = rxq.size(); d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            m_tx[i] = 8'(8'h11 * (i + 1));
            s_txq.push_back(8'(8'h81 + i));
        end
        master_frame(32);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (m_rx[i] !== 8'(8'h81 + i) || rxq[r0 + i] !== m_tx[i] || m_idx[i] !== 2'(i)) begin
                n_err++;
                $display("FAIL four_byte%0d: miso=%h rx=%h idx=%0d need %h %h %0d",
                         i, m_rx[i], rxq[r0 + i], m_idx[i], 8'(8'h81 + i), m_tx[i], i);
            end
        end
        n_vec++;
        if (n_load - l0 != 4 || rxq.size() - r0 != 4 || n_done - d0 != 1) begin
            n_err++;
            $display("FAIL four_counts: loads=%0d rx=%0d done=%0d need 4/4/1", n_load - l0, rxq.size() - r0, n_done - d0);
        end
    endtask

    task automatic test_wrap;
        int r0;
        r0 = rxq.size();
        for (int i = 0; i < 5; i++) begin
            m_tx[i] = 8'($urandom);
            s_txq.push_back(8'($urandom));
        end
        master_frame(40);
        n_vec++;
        if (m_idx[4] !== 2'd0 || m_idx[3] !== 2'd3) begin
            n_err++; $display("FAIL wrap_idx: byte4 idx=%0d byte5 idx=%0d need 3 and 0", m_idx[3], m_idx[4]);
        end
        n_vec++;
        if (rxq.size() - r0 != 5 || rxq[r0 + 4] !== m_tx[4]) begin
            n_err++; $display("FAIL wrap_rx: got %0d bytes last=%h need 5 last=%h", rxq.size() - r0, rxq[r0 + 4], m_tx[4]);
        end
    endtask

    task automatic test_abort;
        int r0, d0, a0;
        r0 = rxq.size(); d0 = n_done; a0 = n_abort;
        m_tx[0] = 8'($urandom);
        m_tx[1] = 8'($urandom);
        s_txq.push_back(8'($urandom));
        s_txq.push_back(8'($urandom));
        master_frame(13);
        n_vec++;
        if (n_abort - a0 != 1 || n_done != d0) begin
            n_err++; $display("FAIL abort_pulse: abort+%0d done+%0d need 1/0", n_abort - a0, n_done - d0);
        end
        n_vec++;
        if (rxq.size() - r0 != 1 || rx_data !== m_tx[0]) begin
            n_err++; $display("FAIL abort_rx_hold: got %0d bytes rx_data=%h need 1 byte %h", rxq.size() - r0, rx_data, m_tx[0]);
        end
        r0 = rxq.size(); d0 = n_done;
        m_tx[0] = 8'h5A;
        s_txq.push_back(8'h96);
        master_frame(8);
        n_vec++;
        if (rxq.size() - r0 != 1 || rx_data !== 8'h5A || m_rx[0] !== 8'h96 || n_done - d0 != 1) begin
            n_err++;
            $display("FAIL after_abort: rx=%h miso=%h done+%0d need 5a 96 1", rx_data, m_rx[0], n_done - d0);
        end
    endtask

    task automatic test_reset_mid;
        int r0, d0, a0;
        @(negedge clk);
        cs = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_busy: got %b need 1", busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({miso, busy, rx_valid, tx_load, byte_idx, rx_data, frame_done, frame_abort} !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset_async: miso=%b busy=%b idx=%0d rx=%h, need all 0", miso, busy, byte_idx, rx_data);
        end
        cs = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        r0 = rxq.size(); d0 = n_done; a0 = n_abort;
        m_tx[0] = 8'hC3;
        s_txq.push_back(8'h3E);
        master_frame(8);
        n_vec++;
        if (rxq.size() - r0 != 1 || rx_data !== 8'hC3 || m_rx[0] !== 8'h3E || n_done - d0 != 1 || n_abort != a0) begin
            n_err++;
            $display("FAIL after_reset: rx=%h miso=%h done+%0d abort+%0d need c3 3e 1 0",
                     rx_data, m_rx[0], n_done - d0, n_abort - a0);
        end
    endtask

    task automatic test_random;
        int nbytes, part, nbits, full, started, r0, l0, d0, a0;
        for (int f = 0; f < 6; f++) begin
            nbytes = int'($urandom_range(1, 5));
            part = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            nbits = (part != 0) ? (nbytes - 1) * 8 + part : nbytes * 8;
            full = nbits / 8;
            started = (nbits + 7) / 8;
            r0 = rxq.size(); l0 = n_load; d0 = n_done; a0 = n_abort;
            for (int i = 0; i < started; i++) begin
                m_tx[i] = 8'($urandom);
                s_txq.push_back(8'($urandom));
            end
            // remember what the slave should send, before the monitor pops it
            for (int i = 0; i < started; i++) m_idx[i] = 2'bxx;
            begin
                logic [7:0] exp_tx[16];
                for (int i = 0; i < started; i++) exp_tx[i] = s_txq[s_txq.size() - started + i];
                master_frame(nbits);
                for (int i = 0; i < full; i++) begin
                    n_vec++;
                    if (m_rx[i] !== exp_tx[i] || rxq[r0 + i] !== m_tx[i] || m_idx[i] !== 2'(i % 4)) begin
                        n_err++;
                        $display("FAIL rand%0d_byte%0d: miso=%h rx=%h idx=%0d need %h %h %0d",
                                 f, i, m_rx[i], rxq[r0 + i], m_idx[i], exp_tx[i], m_tx[i], i % 4);
                    end
                end
            end
            n_vec++;
            if (rxq.size() - r0 != full || n_load - l0 != started ||
                n_done - d0 != ((nbits % 8 == 0) ? 1 : 0) || n_abort - a0 != ((nbits % 8 != 0) ? 1 : 0)) begin
                n_err++;
                $display("FAIL rand%0d_counts nbits=%0d: rx=%0d loads=%0d done=%0d abort=%0d need %0d %0d %0d %0d",
                         f, nbits, rxq.size() - r0, n_load - l0, n_done - d0, n_abort - a0,
                         full, started, (nbits % 8 == 0) ? 1 : 0, (nbits % 8 != 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_four;
        test_wrap;
        test_abort;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
